// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the Asteroids game sequencer and the rest of the game.
// master: the sequencer (game_flow_ctrl). It takes in the frame tick, the fire
//         button, the collision level and lives_zero. It drives the state code,
//         the title zoom, the banner enables, the ship and torpedo enables and
//         the respawn and die pulses.
// slave:  the surrounding logic: frame-tick generator, lives counter and
//         sprite units.
interface game_flow_ctrl_if;
    logic       frame_tick;
    logic       btn_fire;
    logic       collision;
    logic       lives_zero;
    logic [2:0] state;
    logic [7:0] title_scale;
    logic       draw_title;
    logic       draw_gameover;
    logic       ship_visible;
    logic       ship_respawn;
    logic       die_pulse;
    logic       fire_en;
    logic       invulnerable;

    modport master (
        input  frame_tick, btn_fire, collision, lives_zero,
        output state, title_scale, draw_title, draw_gameover, ship_visible,
               ship_respawn, die_pulse, fire_en, invulnerable
    );

    modport slave (
        output frame_tick, btn_fire, collision, lives_zero,
        input  state, title_scale, draw_title, draw_gameover, ship_visible,
               ship_respawn, die_pulse, fire_en, invulnerable
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Asteroids game sequencer. The phases run in this order:
//   title zoom -> wait for start -> play -> death and respawn -> game over.
// Collisions are gated into the lives counter so that each crash gives exactly
// one die pulse. Every output is registered: the registers load values that
// are computed from the next state and the next counter values, so a cause
// becomes visible on the following cycle.
// Ports:
//   clk_25  pixel clock
//   resetN  asynchronous active-low reset
//   gf      game_flow_ctrl_if.master. Carries frame_tick, btn_fire, collision
//           and lives_zero in; state, title_scale, banner and ship enables,
//           ship_respawn, die_pulse, fire_en and invulnerable out.
module game_flow_ctrl #(
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_LOG2    = 2
) (
    input  logic              clk_25,
    input  logic              resetN,
    game_flow_ctrl_if.master  gf
);

    typedef enum logic [2:0] {
        S_TITLE   = 3'd0,
        S_READY   = 3'd1,
        S_PLAY    = 3'd2,
        S_DYING   = 3'd3,
        S_RESPAWN = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    state_t     state_reg, state_next;
    logic [7:0] title_scale_reg, title_scale_next;
    logic [7:0] invuln_cnt_reg, invuln_cnt_next;
    logic [7:0] death_cnt_reg, death_cnt_next;
    logic       fire_armed_reg, fire_armed_next;
    logic       btn_prev_reg;
    logic       draw_title_reg, draw_gameover_reg, ship_visible_reg;
    logic       ship_respawn_reg, die_pulse_reg, fire_en_reg, invulnerable_reg;
    logic       die_next;
    logic       fire_edge;

    assign fire_edge = gf.btn_fire & ~btn_prev_reg;

    always_comb begin
        state_next       = state_reg;
        title_scale_next = title_scale_reg;
        invuln_cnt_next  = invuln_cnt_reg;
        death_cnt_next   = death_cnt_reg;
        fire_armed_next  = fire_armed_reg;
        die_next         = 1'b0;

        case (state_reg)
            S_TITLE: begin
                if (gf.frame_tick && title_scale_reg != 8'd255)
                    title_scale_next = title_scale_reg + 8'd1;
                if (fire_edge || (gf.frame_tick && title_scale_reg == 8'd255))
                    state_next = S_READY;
            end
            S_READY: begin
                if (fire_edge)
                    state_next = S_RESPAWN;
            end
            S_RESPAWN: begin
                state_next = S_PLAY;
            end
            S_PLAY: begin
                if (gf.frame_tick && invuln_cnt_reg != 8'd0)
                    invuln_cnt_next = invuln_cnt_reg - 8'd1;
                // The start press is still held on entry. Torpedoes stay
                // locked until the button has been seen released once.
                if (!gf.btn_fire)
                    fire_armed_next = 1'b1;
                // The death test uses the pre-decrement count, so a tick
                // that lands together with a collision at count 1 still
                // protects the ship.
                if (gf.collision && invuln_cnt_reg == 8'd0) begin
                    die_next       = 1'b1;
                    death_cnt_next = 8'(DEATH_FRAMES);
                    state_next     = S_DYING;
                end else if (gf.lives_zero) begin
                    state_next = S_OVER;
                end
            end
            S_DYING: begin
                if (gf.frame_tick) begin
                    death_cnt_next = death_cnt_reg - 8'd1;
                    if (death_cnt_reg == 8'd1)
                        state_next = gf.lives_zero ? S_OVER : S_RESPAWN;
                end
            end
            S_OVER: begin
                state_next = S_OVER;
            end
            default: begin
                state_next = S_TITLE;
            end
        endcase

        // Load the counter when RESPAWN is entered, so that the invulnerable
        // output is already high during the one-cycle respawn.
        if (state_next == S_RESPAWN) begin
            invuln_cnt_next = 8'(INVULN_FRAMES);
            fire_armed_next = 1'b0;
        end
    end

    always_ff @(posedge clk_25 or negedge resetN) begin
        if (!resetN) begin
            state_reg         <= S_TITLE;
            title_scale_reg   <= 8'd0;
            invuln_cnt_reg    <= 8'd0;
            death_cnt_reg     <= 8'd0;
            fire_armed_reg    <= 1'b0;
            // Reset to 1: a button held through reset produces no edge.
            btn_prev_reg      <= 1'b1;
            draw_title_reg    <= 1'b1;
            draw_gameover_reg <= 1'b0;
            ship_visible_reg  <= 1'b0;
            ship_respawn_reg  <= 1'b0;
            die_pulse_reg     <= 1'b0;
            fire_en_reg       <= 1'b0;
            invulnerable_reg  <= 1'b0;
        end else begin
            state_reg         <= state_next;
            title_scale_reg   <= title_scale_next;
            invuln_cnt_reg    <= invuln_cnt_next;
            death_cnt_reg     <= death_cnt_next;
            fire_armed_reg    <= fire_armed_next;
            btn_prev_reg      <= gf.btn_fire;
            draw_title_reg    <= (state_next == S_TITLE) || (state_next == S_READY);
            draw_gameover_reg <= (state_next == S_OVER);
            ship_visible_reg  <= (state_next == S_PLAY) &&
                                 ((invuln_cnt_next == 8'd0) || invuln_cnt_next[BLINK_LOG2]);
            ship_respawn_reg  <= (state_next == S_RESPAWN);
            die_pulse_reg     <= die_next;
            fire_en_reg       <= (state_next == S_PLAY) && fire_armed_next && gf.btn_fire;
            invulnerable_reg  <= (invuln_cnt_next != 8'd0);
        end
    end

    assign gf.state         = state_reg;
    assign gf.title_scale   = title_scale_reg;
    assign gf.draw_title    = draw_title_reg;
    assign gf.draw_gameover = draw_gameover_reg;
    assign gf.ship_visible  = ship_visible_reg;
    assign gf.ship_respawn  = ship_respawn_reg;
    assign gf.die_pulse     = die_pulse_reg;
    assign gf.fire_en       = fire_en_reg;
    assign gf.invulnerable  = invulnerable_reg;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl with default parameters
// (60 death frames, 120 invulnerable frames, blink bit 2).
module tb_game_flow_ctrl;

    localparam logic [2:0] TITLE = 3'd0, READY = 3'd1, PLAY = 3'd2,
                           DYING = 3'd3, RESPAWN = 3'd4, OVER = 3'd5;

    logic clk_25 = 1'b0;
    logic resetN = 1'b0;
    always #20 clk_25 = ~clk_25;

    game_flow_ctrl_if gf();

    game_flow_ctrl dut (
        .clk_25 (clk_25),
        .resetN (resetN),
        .gf     (gf)
    );

    typedef struct {
        logic       btn;
        logic       coll;
        logic       tick;
        logic       lz;
        logic [2:0] st;
        logic [7:0] scale;
        logic       dt;
        logic       resp;
        logic       vis;
        logic       inv;
        logic       fire;
        logic       die;
    } vec_t;

    vec_t tbl[13];
    vec_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic btn, coll, tick, lz,
                                input logic [2:0] st, input logic [7:0] scale,
                                input logic dt, resp, vis, inv, fire, die);
        vec_t v;
        v.btn = btn; v.coll = coll; v.tick = tick; v.lz = lz;
        v.st = st; v.scale = scale; v.dt = dt; v.resp = resp;
        v.vis = vis; v.inv = inv; v.fire = fire; v.die = die;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs; outputs are then sampled on the falling edge.
    task automatic cyc(input logic btn, coll, tick, lz);
        gf.btn_fire   = btn;
        gf.collision  = coll;
        gf.frame_tick = tick;
        gf.lives_zero = lz;
        @(posedge clk_25);
        @(negedge clk_25);
    endtask

    initial begin
        vec_t e;
        int die_cnt, resp_cnt, dying_cyc, vis_bad, die_k, resp_k;

        gf.btn_fire = 1'b0; gf.collision = 1'b0; gf.frame_tick = 1'b0; gf.lives_zero = 1'b0;

        //            btn coll tick lz  state    scale dt resp vis inv fire die
        tbl[0]  = mk(0, 0, 1, 0, TITLE,   8'd1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, TITLE,   8'd2, 1, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, TITLE,   8'd2, 1, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 0, READY,   8'd2, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk(1, 0, 1, 0, READY,   8'd2, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, READY,   8'd2, 1, 0, 0, 0, 0, 0);
        tbl[6]  = mk(1, 0, 0, 0, RESPAWN, 8'd2, 0, 1, 0, 1, 0, 0);
        tbl[7]  = mk(1, 0, 0, 0, PLAY,    8'd2, 0, 0, 0, 1, 0, 0);
        tbl[8]  = mk(1, 0, 1, 0, PLAY,    8'd2, 0, 0, 1, 1, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, PLAY,    8'd2, 0, 0, 1, 1, 0, 0);
        tbl[10] = mk(1, 0, 0, 0, PLAY,    8'd2, 0, 0, 1, 1, 1, 0);
        tbl[11] = mk(1, 1, 0, 0, PLAY,    8'd2, 0, 0, 1, 1, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, PLAY,    8'd2, 0, 0, 1, 1, 0, 0);

        repeat (3) @(negedge clk_25);
        check("rst_state", 8'(gf.state), 8'(TITLE));
        check("rst_scale", gf.title_scale, 8'd0);
        check("rst_draw_title", 8'(gf.draw_title), 8'd1);
        check("rst_others", {gf.draw_gameover, gf.ship_visible, gf.ship_respawn,
                             gf.die_pulse, gf.fire_en, gf.invulnerable}, 8'd0);
        resetN = 1'b1;

        // Table: title skip, start, respawn, fire arming, collision while invulnerable
        for (int i = 0; i < 13; i++) begin
            sb.push_back(tbl[i]);
            cyc(tbl[i].btn, tbl[i].coll, tbl[i].tick, tbl[i].lz);
            e = sb.pop_front();
            check($sformatf("tbl%0d_state", i), 8'(gf.state), 8'(e.st));
            check($sformatf("tbl%0d_scale", i), gf.title_scale, e.scale);
            check($sformatf("tbl%0d_draw_title", i), 8'(gf.draw_title), 8'(e.dt));
            check($sformatf("tbl%0d_respawn", i), 8'(gf.ship_respawn), 8'(e.resp));
            check($sformatf("tbl%0d_visible", i), 8'(gf.ship_visible), 8'(e.vis));
            check($sformatf("tbl%0d_invuln", i), 8'(gf.invulnerable), 8'(e.inv));
            check($sformatf("tbl%0d_fire_en", i), 8'(gf.fire_en), 8'(e.fire));
            check($sformatf("tbl%0d_die", i), 8'(gf.die_pulse), 8'(e.die));
        end

        // Count down invulnerability from 118 to 1
        for (int i = 0; i < 117; i++) cyc(0, 0, 1, 0);
        check("inv_at_1", 8'(gf.invulnerable), 8'd1);
        check("blink_off_at_1", 8'(gf.ship_visible), 8'd0);

        // Collision and tick together at count 1: protected by the pre-decrement value
        cyc(0, 1, 1, 0);
        check("edge_no_die", 8'(gf.die_pulse), 8'd0);
        check("edge_state", 8'(gf.state), 8'(PLAY));
        check("edge_inv_clear", 8'(gf.invulnerable), 8'd0);
        check("edge_visible", 8'(gf.ship_visible), 8'd1);

        // Collision held 200 cycles, tick every other cycle
        die_cnt = 0; resp_cnt = 0; dying_cyc = 0; vis_bad = 0; die_k = -1; resp_k = -1;
        for (int k = 0; k < 200; k++) begin
            cyc(0, 1, (k % 2 == 0), 0);
            if (gf.die_pulse) begin die_cnt++; if (die_k < 0) die_k = k; end
            if (gf.ship_respawn) begin resp_cnt++; if (resp_k < 0) resp_k = k; end
            if (gf.state == DYING) dying_cyc++;
            if (k <= 120 && gf.ship_visible) vis_bad++;
        end
        check("held_die_count", 8'(die_cnt), 8'd1);
        check("held_die_cycle", 8'(die_k), 8'd0);
        check("held_dying_cycles", 8'(dying_cyc), 8'd120);
        check("held_respawn_count", 8'(resp_cnt), 8'd1);
        check("held_respawn_cycle", 8'(resp_k), 8'd120);
        check("held_hidden", 8'(vis_bad), 8'd0);
        check("held_state", 8'(gf.state), 8'(PLAY));
        check("held_invuln", 8'(gf.invulnerable), 8'd1);

        // Run out the remaining 81 invulnerable frames, then crash with lives_zero
        for (int i = 0; i < 81; i++) cyc(0, 0, 1, 0);
        check("inv_done", 8'(gf.invulnerable), 8'd0);
        cyc(0, 1, 0, 0);
        check("crash_die", 8'(gf.die_pulse), 8'd1);
        check("crash_state", 8'(gf.state), 8'(DYING));
        resp_cnt = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(0, 0, 1, 1);
            if (gf.ship_respawn) resp_cnt++;
            if (i == 58) check("lz_still_dying", 8'(gf.state), 8'(DYING));
        end
        check("lz_over", 8'(gf.state), 8'(OVER));
        check("lz_gameover", 8'(gf.draw_gameover), 8'd1);
        check("lz_no_respawn", 8'(resp_cnt), 8'd0);
        check("over_enables", {gf.draw_title, gf.ship_visible, gf.fire_en, gf.invulnerable}, 8'd0);
        cyc(1, 0, 1, 0); cyc(0, 0, 0, 0); cyc(1, 1, 1, 0);
        check("over_terminal", 8'(gf.state), 8'(OVER));

        // Asynchronous reset, observed before any clock edge
        #2 resetN = 1'b0;
        #1;
        check("arst_state", 8'(gf.state), 8'(TITLE));
        check("arst_scale", gf.title_scale, 8'd0);
        check("arst_gameover", 8'(gf.draw_gameover), 8'd0);
        check("arst_draw_title", 8'(gf.draw_title), 8'd1);
        gf.btn_fire = 1'b0; gf.collision = 1'b0; gf.frame_tick = 1'b0; gf.lives_zero = 1'b0;
        @(negedge clk_25);
        resetN = 1'b1;

        // Full title zoom with no button
        n_cmp++;
        begin
            int bad = 0;
            for (int i = 1; i <= 255; i++) begin
                cyc(0, 0, 1, 0);
                if (gf.title_scale !== 8'(i) || gf.state !== TITLE || gf.draw_title !== 1'b1) bad++;
            end
            if (bad != 0) begin
                n_err++;
                $display("FAIL zoom_ramp: got %0d bad steps expected 0", bad);
            end
        end
        cyc(0, 0, 1, 0);
        check("zoom_ready", 8'(gf.state), 8'(READY));
        check("zoom_sat", gf.title_scale, 8'd255);
        check("zoom_draw_title", 8'(gf.draw_title), 8'd1);

        // Start, then lives_zero in PLAY without a death
        cyc(1, 0, 0, 0);
        check("start_respawn", 8'(gf.state), 8'(RESPAWN));
        cyc(0, 0, 0, 0);
        check("start_play", 8'(gf.state), 8'(PLAY));
        cyc(0, 0, 0, 1);
        check("play_lz_over", 8'(gf.state), 8'(OVER));
        check("play_lz_no_die", 8'(gf.die_pulse), 8'd0);

        // Button held through reset gives no edge
        resetN = 1'b0;
        gf.btn_fire = 1'b1; gf.lives_zero = 1'b0;
        @(negedge clk_25);
        resetN = 1'b1;
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        check("held_btn_no_skip", 8'(gf.state), 8'(TITLE));
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check("release_press_skip", 8'(gf.state), 8'(READY));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
